// File: rtl/pw_bit_pkg.sv
// Shared types for the pw_bit frame scheduler: FSM states, the config
// triple carried to the pulse-width cell, and the config sanity check.
package pw_bit_pkg;

  localparam int PW_BIT_CFG_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_PERIOD,
    ST_CFG_HI,
    ST_CFG_LO,
    ST_DATA,
    ST_DRAIN
  } pw_bit_sched_state_t;

  typedef struct packed {
    logic [PW_BIT_CFG_W-1:0] period;
    logic [PW_BIT_CFG_W-1:0] duty_hi;
    logic [PW_BIT_CFG_W-1:0] duty_lo;
  } pw_bit_cfg_t;

  // A config is usable when the period is non-zero and neither duty
  // phase is longer than the period (all unsigned, full width).
  function automatic logic pw_bit_cfg_valid(input pw_bit_cfg_t c);
    return (c.period != '0) && (c.duty_hi <= c.period) && (c.duty_lo <= c.period);
  endfunction

endpackage

// File: rtl/pw_bit_rr_arb.sv
// Combinational round-robin arbiter: searches upward from the requester
// after last_grant_i, wrapping modulo NUM_REQ.
module pw_bit_rr_arb
  import pw_bit_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic [ID_W-1:0]    grant_o,
  output logic               any_req_o
);

  logic [ID_W:0] cand;
  logic          found;

  // Walk the NUM_REQ candidates in priority order and keep the first hit.
  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = {1'b0, last_grant_i} + (ID_W+1)'(off);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!found && req_i[cand[ID_W-1:0]]) begin
        found   = 1'b1;
        grant_o = cand[ID_W-1:0];
      end
    end
    any_req_o = found;
  end

endmodule

// File: rtl/pw_bit_sched.sv
// Frame scheduler sharing one pw_bit_cell between NUM_REQ requesters:
// round-robin grant per frame, config beats only when the cell's loaded
// settings differ, then data pass-through (or discard for bad config).
module pw_bit_sched
  import pw_bit_pkg::*;
#(
  parameter int NUM_REQ              = 4,
  parameter int DATA_AXIS_DATA_WIDTH = 8,
  parameter int CFG_AXIS_DATA_WIDTH  = 32,
  localparam int ID_W                = $clog2(NUM_REQ)
) (
  input  logic                                    aclk,
  input  logic                                    areset,
  input  logic [NUM_REQ*DATA_AXIS_DATA_WIDTH-1:0] req_s_axis_tdata,
  input  logic [NUM_REQ-1:0]                      req_s_axis_tlast,
  input  logic [NUM_REQ-1:0]                      req_s_axis_tvalid,
  output logic [NUM_REQ-1:0]                      req_s_axis_tready,
  input  logic [NUM_REQ*CFG_AXIS_DATA_WIDTH-1:0]  req_cfg_period,
  input  logic [NUM_REQ*CFG_AXIS_DATA_WIDTH-1:0]  req_cfg_duty_hi,
  input  logic [NUM_REQ*CFG_AXIS_DATA_WIDTH-1:0]  req_cfg_duty_lo,
  output logic [DATA_AXIS_DATA_WIDTH-1:0]         data_m_axis_tdata,
  output logic                                    data_m_axis_tlast,
  output logic                                    data_m_axis_tvalid,
  input  logic                                    data_m_axis_tready,
  output logic [CFG_AXIS_DATA_WIDTH-1:0]          cfg_period_m_axis_tdata,
  output logic                                    cfg_period_m_axis_tvalid,
  input  logic                                    cfg_period_m_axis_tready,
  output logic [CFG_AXIS_DATA_WIDTH-1:0]          cfg_duty_hi_m_axis_tdata,
  output logic                                    cfg_duty_hi_m_axis_tvalid,
  input  logic                                    cfg_duty_hi_m_axis_tready,
  output logic [CFG_AXIS_DATA_WIDTH-1:0]          cfg_duty_lo_m_axis_tdata,
  output logic                                    cfg_duty_lo_m_axis_tvalid,
  input  logic                                    cfg_duty_lo_m_axis_tready,
  output logic [ID_W-1:0]                         grant_id,
  output logic                                    busy,
  output logic                                    frame_done,
  output logic                                    cfg_err
);

  pw_bit_sched_state_t state_q, state_d;

  logic [ID_W-1:0] grant_q;
  logic [ID_W-1:0] last_grant_q;
  pw_bit_cfg_t     cfg_q;
  pw_bit_cfg_t     loaded_cfg_q;
  logic [ID_W-1:0] loaded_id_q;
  logic            cfg_loaded_q;
  logic            period_vld_q, hi_vld_q, lo_vld_q;
  logic            frame_done_q, cfg_err_q;

  logic [ID_W-1:0]                 arbGrant;
  logic                            anyReq;
  pw_bit_cfg_t                     winCfg;
  logic                            winValid;
  logic                            winSkip;
  logic [DATA_AXIS_DATA_WIDTH-1:0] selData;
  logic                            selLast;
  logic                            selValid;
  logic                            loHs;

  pw_bit_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i        (req_s_axis_tvalid),
    .last_grant_i (last_grant_q),
    .grant_o      (arbGrant),
    .any_req_o    (anyReq)
  );

  // Candidate winner's config and the checks that pick the first state.
  always_comb begin
    winCfg.period  = req_cfg_period [int'(arbGrant)*CFG_AXIS_DATA_WIDTH +: CFG_AXIS_DATA_WIDTH];
    winCfg.duty_hi = req_cfg_duty_hi[int'(arbGrant)*CFG_AXIS_DATA_WIDTH +: CFG_AXIS_DATA_WIDTH];
    winCfg.duty_lo = req_cfg_duty_lo[int'(arbGrant)*CFG_AXIS_DATA_WIDTH +: CFG_AXIS_DATA_WIDTH];
    winValid       = pw_bit_cfg_valid(winCfg);
    winSkip        = cfg_loaded_q && (loaded_id_q == arbGrant) && (loaded_cfg_q == winCfg);
  end

  assign selData  = req_s_axis_tdata[int'(grant_q)*DATA_AXIS_DATA_WIDTH +: DATA_AXIS_DATA_WIDTH];
  assign selLast  = req_s_axis_tlast[grant_q];
  assign selValid = req_s_axis_tvalid[grant_q];
  assign loHs     = (state_q == ST_CFG_LO) && lo_vld_q && cfg_duty_lo_m_axis_tready;

  // Next-state logic plus the data-path muxing that depends on state.
  always_comb begin
    state_d            = state_q;
    data_m_axis_tdata  = '0;
    data_m_axis_tlast  = 1'b0;
    data_m_axis_tvalid = 1'b0;
    req_s_axis_tready  = '0;
    case (state_q)
      ST_IDLE: begin
        if (anyReq) begin
          if (!winValid)    state_d = ST_DRAIN;
          else if (winSkip) state_d = ST_DATA;
          else              state_d = ST_CFG_PERIOD;
        end
      end
      ST_CFG_PERIOD: begin
        if (period_vld_q && cfg_period_m_axis_tready) state_d = ST_CFG_HI;
      end
      ST_CFG_HI: begin
        if (hi_vld_q && cfg_duty_hi_m_axis_tready) state_d = ST_CFG_LO;
      end
      ST_CFG_LO: begin
        if (loHs) state_d = ST_DATA;
      end
      ST_DATA: begin
        data_m_axis_tdata          = selData;
        data_m_axis_tlast          = selLast;
        data_m_axis_tvalid         = selValid;
        req_s_axis_tready[grant_q] = data_m_axis_tready;
        if (selValid && selLast && data_m_axis_tready) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        req_s_axis_tready[grant_q] = 1'b1;
        if (selValid && selLast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, grant, snapshot and status pulses.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ-1);
      cfg_q        <= '0;
      period_vld_q <= 1'b0;
      hi_vld_q     <= 1'b0;
      lo_vld_q     <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_vld_q <= (state_d == ST_CFG_PERIOD);
      hi_vld_q     <= (state_d == ST_CFG_HI);
      lo_vld_q     <= (state_d == ST_CFG_LO);
      frame_done_q <= (state_q == ST_DATA) && (state_d == ST_IDLE);
      cfg_err_q    <= (state_q == ST_IDLE) && (state_d == ST_DRAIN);
      if ((state_q == ST_IDLE) && anyReq) begin
        grant_q <= arbGrant;
        cfg_q   <= winCfg;
      end
      if (((state_q == ST_DATA) || (state_q == ST_DRAIN)) && (state_d == ST_IDLE)) begin
        last_grant_q <= grant_q;
      end
    end
  end

  // Record what the cell now holds once the last config beat lands.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cfg_loaded_q <= 1'b0;
      loaded_id_q  <= '0;
      loaded_cfg_q <= '0;
    end else if (loHs) begin
      cfg_loaded_q <= 1'b1;
      loaded_id_q  <= grant_q;
      loaded_cfg_q <= cfg_q;
    end
  end

  assign cfg_period_m_axis_tvalid  = period_vld_q;
  assign cfg_duty_hi_m_axis_tvalid = hi_vld_q;
  assign cfg_duty_lo_m_axis_tvalid = lo_vld_q;
  assign cfg_period_m_axis_tdata   = period_vld_q ? cfg_q.period  : '0;
  assign cfg_duty_hi_m_axis_tdata  = hi_vld_q     ? cfg_q.duty_hi : '0;
  assign cfg_duty_lo_m_axis_tdata  = lo_vld_q     ? cfg_q.duty_lo : '0;
  assign grant_id                  = grant_q;
  assign busy                      = (state_q != ST_IDLE);
  assign frame_done                = frame_done_q;
  assign cfg_err                   = cfg_err_q;

endmodule

// File: tb/tb_pw_bit_sched.sv
// Scoreboard bench for pw_bit_sched: directed frames push expected beats
// and grants; a negedge monitor pops and compares on every handshake.
module tb_pw_bit_sched;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int CW = 32;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic [DW-1:0] reqData[NR];
  logic          reqLast[NR];
  logic          reqVld[NR];
  logic [CW-1:0] reqPeriod[NR];
  logic [CW-1:0] reqHi[NR];
  logic [CW-1:0] reqLo[NR];

  logic [NR*DW-1:0] req_s_axis_tdata;
  logic [NR-1:0]    req_s_axis_tlast, req_s_axis_tvalid, req_s_axis_tready;
  logic [NR*CW-1:0] req_cfg_period, req_cfg_duty_hi, req_cfg_duty_lo;
  logic [DW-1:0]    data_m_axis_tdata;
  logic             data_m_axis_tlast, data_m_axis_tvalid;
  logic [CW-1:0]    cfg_period_m_axis_tdata, cfg_duty_hi_m_axis_tdata, cfg_duty_lo_m_axis_tdata;
  logic             cfg_period_m_axis_tvalid, cfg_duty_hi_m_axis_tvalid, cfg_duty_lo_m_axis_tvalid;
  logic [1:0]       grant_id;
  logic             busy, frame_done, cfg_err;
  logic             dataRdy, periodRdy, hiRdy, loRdy;

  // Pack the per-requester bench arrays into the DUT's flat vectors.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_s_axis_tdata[i*DW +: DW] = reqData[i];
      req_s_axis_tlast[i]          = reqLast[i];
      req_s_axis_tvalid[i]         = reqVld[i];
      req_cfg_period[i*CW +: CW]   = reqPeriod[i];
      req_cfg_duty_hi[i*CW +: CW]  = reqHi[i];
      req_cfg_duty_lo[i*CW +: CW]  = reqLo[i];
    end
  end

  pw_bit_sched #(.NUM_REQ(NR), .DATA_AXIS_DATA_WIDTH(DW), .CFG_AXIS_DATA_WIDTH(CW)) dut (
    .aclk                      (aclk),
    .areset                    (areset),
    .req_s_axis_tdata          (req_s_axis_tdata),
    .req_s_axis_tlast          (req_s_axis_tlast),
    .req_s_axis_tvalid         (req_s_axis_tvalid),
    .req_s_axis_tready         (req_s_axis_tready),
    .req_cfg_period            (req_cfg_period),
    .req_cfg_duty_hi           (req_cfg_duty_hi),
    .req_cfg_duty_lo           (req_cfg_duty_lo),
    .data_m_axis_tdata         (data_m_axis_tdata),
    .data_m_axis_tlast         (data_m_axis_tlast),
    .data_m_axis_tvalid        (data_m_axis_tvalid),
    .data_m_axis_tready        (dataRdy),
    .cfg_period_m_axis_tdata   (cfg_period_m_axis_tdata),
    .cfg_period_m_axis_tvalid  (cfg_period_m_axis_tvalid),
    .cfg_period_m_axis_tready  (periodRdy),
    .cfg_duty_hi_m_axis_tdata  (cfg_duty_hi_m_axis_tdata),
    .cfg_duty_hi_m_axis_tvalid (cfg_duty_hi_m_axis_tvalid),
    .cfg_duty_hi_m_axis_tready (hiRdy),
    .cfg_duty_lo_m_axis_tdata  (cfg_duty_lo_m_axis_tdata),
    .cfg_duty_lo_m_axis_tvalid (cfg_duty_lo_m_axis_tvalid),
    .cfg_duty_lo_m_axis_tready (loRdy),
    .grant_id                  (grant_id),
    .busy                      (busy),
    .frame_done                (frame_done),
    .cfg_err                   (cfg_err)
  );

  // Scoreboard: kind 0 = config issued, 1 = config skipped, 2 = drained.
  logic [CW-1:0] expPeriodQ[$], expHiQ[$], expLoQ[$];
  logic [DW:0]   expDataQ[$];
  int            expGrantQ[$], expKindQ[$];

  int checks = 0, failures = 0, frameDoneCnt = 0, cfgErrCnt = 0;
  bit drainMode = 0, rrMode = 0;
  int rrGrants = 0, idleRun = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flagError(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " data tvalid"}, 64'(data_m_axis_tvalid), 64'(0));
    checkOutput({tag, " data tdata"},  64'(data_m_axis_tdata), 64'(0));
    checkOutput({tag, " data tlast"},  64'(data_m_axis_tlast), 64'(0));
    checkOutput({tag, " period tvalid"}, 64'(cfg_period_m_axis_tvalid), 64'(0));
    checkOutput({tag, " hi tvalid"},   64'(cfg_duty_hi_m_axis_tvalid), 64'(0));
    checkOutput({tag, " lo tvalid"},   64'(cfg_duty_lo_m_axis_tvalid), 64'(0));
    checkOutput({tag, " period tdata"}, 64'(cfg_period_m_axis_tdata), 64'(0));
    checkOutput({tag, " hi tdata"},    64'(cfg_duty_hi_m_axis_tdata), 64'(0));
    checkOutput({tag, " lo tdata"},    64'(cfg_duty_lo_m_axis_tdata), 64'(0));
    checkOutput({tag, " req tready"},  64'(req_s_axis_tready), 64'(0));
    checkOutput({tag, " grant_id"},    64'(grant_id), 64'(0));
    checkOutput({tag, " busy"},        64'(busy), 64'(0));
    checkOutput({tag, " frame_done"},  64'(frame_done), 64'(0));
    checkOutput({tag, " cfg_err"},     64'(cfg_err), 64'(0));
  endtask

  task automatic expectFrame(input int id, input int kind, input int n, input logic [DW-1:0] beats[8]);
    expGrantQ.push_back(id);
    expKindQ.push_back(kind);
    if (kind == 0) begin
      expPeriodQ.push_back(reqPeriod[id]);
      expHiQ.push_back(reqHi[id]);
      expLoQ.push_back(reqLo[id]);
    end
    if (kind != 2) begin
      for (int i = 0; i < n; i++) expDataQ.push_back({(i == n-1), beats[i]});
    end
  endtask

  task automatic waitReady(input int id);
    int cnt = 0;
    while (1) begin
      @(negedge aclk);
      if (req_s_axis_tready[id]) break;
      cnt++;
      if (cnt > 300) begin
        flagError($sformatf("ready timeout req%0d", id));
        break;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input int id, input int n, input logic [DW-1:0] beats[8]);
    for (int i = 0; i < n; i++) begin
      reqVld[id]  = 1'b1;
      reqData[id] = beats[i];
      reqLast[id] = (i == n-1);
      waitReady(id);
    end
    reqVld[id]  = 1'b0;
    reqLast[id] = 1'b0;
    reqData[id] = '0;
  endtask

  // Monitor: pops the scoreboard on every handshake and new grant.
  initial begin : monitor
    bit busyPrev = 0, hiPend = 0, dataPend = 0;
    logic [CW-1:0] hiHeld;
    logic [DW:0]   dataHeld;
    int id, kind;
    forever begin
      @(negedge aclk);
      if (areset) begin
        busyPrev = 0; hiPend = 0; dataPend = 0;
      end else begin
        if (cfg_period_m_axis_tvalid && periodRdy) begin
          if (expPeriodQ.size() == 0) flagError("unexpected period beat");
          else checkOutput("period beat", 64'(cfg_period_m_axis_tdata), 64'(expPeriodQ.pop_front()));
        end
        if (cfg_duty_hi_m_axis_tvalid && hiRdy) begin
          if (expHiQ.size() == 0) flagError("unexpected duty_hi beat");
          else checkOutput("duty_hi beat", 64'(cfg_duty_hi_m_axis_tdata), 64'(expHiQ.pop_front()));
        end
        if (cfg_duty_lo_m_axis_tvalid && loRdy) begin
          if (expLoQ.size() == 0) flagError("unexpected duty_lo beat");
          else checkOutput("duty_lo beat", 64'(cfg_duty_lo_m_axis_tdata), 64'(expLoQ.pop_front()));
        end
        if (data_m_axis_tvalid && dataRdy) begin
          if (expDataQ.size() == 0) flagError("unexpected data beat");
          else checkOutput("data beat {tlast,tdata}", 64'({data_m_axis_tlast, data_m_axis_tdata}), 64'(expDataQ.pop_front()));
        end
        if (hiPend) begin
          checkOutput("duty_hi held tvalid", 64'(cfg_duty_hi_m_axis_tvalid), 64'(1));
          checkOutput("duty_hi held tdata", 64'(cfg_duty_hi_m_axis_tdata), 64'(hiHeld));
        end
        hiPend = cfg_duty_hi_m_axis_tvalid && !hiRdy;
        hiHeld = cfg_duty_hi_m_axis_tdata;
        if (dataPend) begin
          checkOutput("data held tvalid", 64'(data_m_axis_tvalid), 64'(1));
          checkOutput("data held beat", 64'({data_m_axis_tlast, data_m_axis_tdata}), 64'(dataHeld));
        end
        dataPend = data_m_axis_tvalid && !dataRdy;
        dataHeld = {data_m_axis_tlast, data_m_axis_tdata};
        if (busy && !busyPrev) begin
          if (expGrantQ.size() == 0) flagError("unexpected grant");
          else begin
            id   = expGrantQ.pop_front();
            kind = expKindQ.pop_front();
            checkOutput("grant_id", 64'(grant_id), 64'(id));
            checkOutput("period tvalid after grant", 64'(cfg_period_m_axis_tvalid), 64'(kind == 0));
            checkOutput("data tvalid after grant", 64'(data_m_axis_tvalid), 64'(kind == 1));
            checkOutput("cfg_err after grant", 64'(cfg_err), 64'(kind == 2));
          end
          if (rrMode) begin
            if (rrGrants > 0) checkOutput("rr frame gap", 64'(idleRun), 64'(1));
            rrGrants++;
          end
        end
        if (!busy) idleRun = busyPrev ? 1 : idleRun + 1;
        if (drainMode && busy) begin
          checkOutput("drain data tvalid", 64'(data_m_axis_tvalid), 64'(0));
          checkOutput("drain req2 tready", 64'(req_s_axis_tready[2]), 64'(1));
        end
        if (frame_done) frameDoneCnt++;
        if (cfg_err) cfgErrCnt++;
        busyPrev = busy;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    logic [DW-1:0] b[8];
    int w;
    areset = 1'b0;
    dataRdy = 1'b1; periodRdy = 1'b1; hiRdy = 1'b1; loRdy = 1'b1;
    for (int i = 0; i < NR; i++) begin
      reqVld[i] = 1'b0; reqLast[i] = 1'b0; reqData[i] = '0;
    end
    reqPeriod[0] = 100; reqHi[0] = 75; reqLo[0] = 25;
    reqPeriod[1] = 200; reqHi[1] = 20; reqLo[1] = 10;
    reqPeriod[2] = 40;  reqHi[2] = 10; reqLo[2] = 30;
    reqPeriod[3] = 80;  reqHi[3] = 40; reqLo[3] = 40;
    #1 areset = 1'b1;
    #1 checkResetOutputs("reset");
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;

    $display("[TB] single frame");
    b = '{8'hCC, 8'h33, 8'hF0, 0, 0, 0, 0, 0};
    expectFrame(0, 0, 3, b);
    applyStimulus(0, 3, b);
    repeat (3) @(posedge aclk); #1;
    checkOutput("frame_done count single", 64'(frameDoneCnt), 64'(1));

    $display("[TB] config skip then change");
    b = '{8'h11, 8'h22, 0, 0, 0, 0, 0, 0};
    expectFrame(0, 1, 2, b);
    applyStimulus(0, 2, b);
    repeat (3) @(posedge aclk); #1;
    reqHi[0] = 60;
    b = '{8'h44, 8'h55, 0, 0, 0, 0, 0, 0};
    expectFrame(0, 0, 2, b);
    applyStimulus(0, 2, b);
    repeat (3) @(posedge aclk); #1;
    checkOutput("frame_done count skip", 64'(frameDoneCnt), 64'(3));

    $display("[TB] round robin");
    b = '{8'h66, 0, 0, 0, 0, 0, 0, 0};
    expectFrame(1, 0, 1, b);
    applyStimulus(1, 1, b);
    repeat (3) @(posedge aclk); #1;
    b = '{8'hA0, 8'hA1, 0, 0, 0, 0, 0, 0};
    expectFrame(2, 0, 2, b);
    b = '{8'hB0, 8'hB1, 0, 0, 0, 0, 0, 0};
    expectFrame(3, 0, 2, b);
    b = '{8'hC0, 0, 0, 0, 0, 0, 0, 0};
    expectFrame(1, 0, 1, b);
    rrMode = 1;
    fork
      applyStimulus(1, 1, '{8'hC0, 0, 0, 0, 0, 0, 0, 0});
      applyStimulus(2, 2, '{8'hA0, 8'hA1, 0, 0, 0, 0, 0, 0});
      applyStimulus(3, 2, '{8'hB0, 8'hB1, 0, 0, 0, 0, 0, 0});
    join
    repeat (3) @(posedge aclk); #1;
    rrMode = 0;
    checkOutput("rr grants seen", 64'(rrGrants), 64'(3));
    checkOutput("frame_done count rr", 64'(frameDoneCnt), 64'(7));

    $display("[TB] rejected config");
    reqPeriod[2] = 50; reqHi[2] = 60; reqLo[2] = 10;
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 0, 0};
    expectFrame(2, 2, 4, b);
    drainMode = 1;
    applyStimulus(2, 4, b);
    repeat (3) @(posedge aclk); #1;
    drainMode = 0;
    checkOutput("cfg_err count", 64'(cfgErrCnt), 64'(1));
    checkOutput("frame_done count drain", 64'(frameDoneCnt), 64'(7));

    $display("[TB] backpressure");
    hiRdy = 1'b0;
    b = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 0, 0, 0, 0};
    expectFrame(3, 0, 4, b);
    fork
      applyStimulus(3, 4, '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 0, 0, 0, 0});
      begin
        w = 0;
        while (!cfg_duty_hi_m_axis_tvalid && w < 100) begin
          @(negedge aclk);
          w++;
        end
        if (w >= 100) flagError("duty_hi tvalid timeout");
        repeat (10) @(posedge aclk);
        #1 hiRdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
          @(posedge aclk);
          #1 dataRdy = ~dataRdy;
        end
        dataRdy = 1'b1;
      end
    join
    repeat (3) @(posedge aclk); #1;
    checkOutput("frame_done count backpressure", 64'(frameDoneCnt), 64'(8));

    $display("[TB] reset mid-frame");
    reqHi[0] = 75;
    b = '{8'hCC, 0, 0, 0, 0, 0, 0, 0};
    expectFrame(0, 0, 1, b);
    expDataQ.pop_back();
    expDataQ.push_back({1'b0, 8'hCC});
    reqVld[0] = 1'b1; reqData[0] = 8'hCC; reqLast[0] = 1'b0;
    waitReady(0);
    dataRdy = 1'b0;
    reqData[0] = 8'h33;
    @(negedge aclk);
    checkOutput("beat2 presented", 64'({data_m_axis_tvalid, data_m_axis_tdata}), 64'({1'b1, 8'h33}));
    #2 areset = 1'b1;
    #1 checkResetOutputs("mid-frame reset");
    reqVld[0] = 1'b0; reqData[0] = '0;
    dataRdy = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    b = '{8'hCC, 8'h33, 8'hF0, 0, 0, 0, 0, 0};
    expectFrame(0, 0, 3, b);
    applyStimulus(0, 3, b);
    repeat (3) @(posedge aclk); #1;
    checkOutput("frame_done count after reset", 64'(frameDoneCnt), 64'(9));

    checkOutput("leftover period beats", 64'(expPeriodQ.size()), 64'(0));
    checkOutput("leftover duty_hi beats", 64'(expHiQ.size()), 64'(0));
    checkOutput("leftover duty_lo beats", 64'(expLoQ.size()), 64'(0));
    checkOutput("leftover data beats", 64'(expDataQ.size()), 64'(0));
    checkOutput("leftover grants", 64'(expGrantQ.size()), 64'(0));
    checkOutput("cfg_err total", 64'(cfgErrCnt), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
